// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DROP  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_STEP           = 32'd4;

  // Redirect targets are forced to a word boundary.
  function automatic logic [31:0] align_pc(input logic [31:0] a);
    return a & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory handshake plus hazard/redirect inputs and IF/ID outputs of the fetch stage.
interface if_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] im;
  logic [31:0] pci;
  logic        if_valid;

  modport master (
    output imem_req, imem_addr, im, pci, if_valid,
    input  imem_ack, imem_data, stall, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, im, pci, if_valid,
    output imem_ack, imem_data, stall, redirect, redirect_pc
  );
endinterface

// File: rtl/if_pend_buf.sv
// One-entry holding register for an instruction fetched while decode is stalled.
module if_pend_buf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        drain,
  input  logic        clear,
  input  logic [31:0] instr_in,
  input  logic [31:0] pci_in,
  output logic [31:0] instr,
  output logic [31:0] pci,
  output logic        valid
);

  // Only the occupancy flag is reset; the payload is qualified by it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     valid <= 1'b0;
    else if (clear) valid <= 1'b0;
    else if (load)  valid <= 1'b1;
    else if (drain) valid <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (load && !clear) begin
      instr <= instr_in;
      pci   <= pci_in;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, req/ack fetch FSM and IF/ID register.
// Define IF_PERF_CNT_EN to add the fetch_count/stall_count performance counters.
module if_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  if_stage_if.master  bus
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);

  fetch_state_e state, state_nxt;
  logic [31:0]  pc, drop_addr, req_addr;
  logic [31:0]  im_q, pci_q;
  logic         vld_q, req, enter_drop, cap;
  logic [31:0]  pend_instr, pend_pci;
  logic         pend_valid, pend_load, pend_drain, deliver;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req        = 1'b0;
    req_addr   = pc;
    enter_drop = 1'b0;
    case (state)
      IDLE:  state_nxt = FETCH;
      FETCH: begin
        req = !pend_valid;
        if (bus.redirect && req && !bus.imem_ack) begin
          enter_drop = 1'b1;
          state_nxt  = DROP;
        end
      end
      // Keep the abandoned request alive at its old address until the memory acks it.
      DROP: begin
        req      = 1'b1;
        req_addr = drop_addr;
        if (bus.imem_ack) state_nxt = FETCH;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign cap        = (state == FETCH) && req && bus.imem_ack && !bus.redirect;
  assign pend_load  = cap && bus.stall;
  assign pend_drain = !bus.redirect && !bus.stall && pend_valid;
  assign deliver    = !bus.redirect && !bus.stall && (pend_valid || cap);

  always_ff @(posedge clk) begin
    if (enter_drop) drop_addr <= pc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc    <= RESET_PC;
      im_q  <= NOP_INSTR;
      pci_q <= 32'h0;
      vld_q <= 1'b0;
    end else if (bus.redirect) begin
      pc    <= align_pc(bus.redirect_pc);
      im_q  <= NOP_INSTR;
      vld_q <= 1'b0;
    end else begin
      if (cap) pc <= pc + PC_STEP;
      if (!bus.stall) begin
        if (pend_valid) begin
          im_q  <= pend_instr;
          pci_q <= pend_pci;
          vld_q <= 1'b1;
        end else if (cap) begin
          im_q  <= bus.imem_data;
          pci_q <= pc + PC_STEP;
          vld_q <= 1'b1;
        end else begin
          im_q  <= NOP_INSTR;
          vld_q <= 1'b0;
        end
      end
    end
  end

  if_pend_buf u_pend (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (pend_load),
    .drain    (pend_drain),
    .clear    (bus.redirect),
    .instr_in (bus.imem_data),
    .pci_in   (pc + PC_STEP),
    .instr    (pend_instr),
    .pci      (pend_pci),
    .valid    (pend_valid)
  );

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count <= 32'h0;
      stall_count <= 32'h0;
    end else begin
      if (deliver)   fetch_count <= fetch_count + 32'd1;
      if (bus.stall) stall_count <= stall_count + 32'd1;
    end
  end
`else
  logic unused_deliver;
  assign unused_deliver = deliver;
`endif

  assign bus.imem_req  = req;
  assign bus.imem_addr = req_addr;
  assign bus.im        = im_q;
  assign bus.pci       = pci_q;
  assign bus.if_valid  = vld_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage; the memory returns {16'hA5A5, addr[15:0]} for every fetch.
module tb_if_stage;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  if_stage_if bus ();

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_count, stall_count;
`endif

  if_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef IF_PERF_CNT_EN
    ,
    .fetch_count (fetch_count),
    .stall_count (stall_count)
`endif
  );

  assign bus.imem_data = {16'hA5A5, bus.imem_addr[15:0]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] im, input logic [31:0] pci,
                          input logic vld);
    check({tag, ".im"},    bus.im, im);
    check({tag, ".pci"},   bus.pci, pci);
    check({tag, ".valid"}, {31'h0, bus.if_valid}, {31'h0, vld});
  endtask

  task automatic chk_req(input string tag, input logic req, input logic [31:0] addr);
    check({tag, ".req"},  {31'h0, bus.imem_req}, {31'h0, req});
    if (req) check({tag, ".addr"}, bus.imem_addr, addr);
  endtask

  initial begin
    n_chk           = 0;
    n_fail          = 0;
    rst_n           = 1'b1;
    bus.imem_ack    = 1'b0;
    bus.stall       = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;

    #2 rst_n = 1'b0;
    #1;
    chk_ifid("reset", 32'h0, 32'h0, 1'b0);
    chk_req("reset", 1'b0, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    bus.imem_ack = 1'b1;

    // Back-to-back fetch with ack tied high
    tick();
    chk_req("idle2fetch", 1'b1, 32'h0);
    check("idle2fetch.valid", {31'h0, bus.if_valid}, 32'h0);
    tick(); chk_ifid("seq0", 32'hA5A5_0000, 32'h4,  1'b1); chk_req("seq0", 1'b1, 32'h4);
    tick(); chk_ifid("seq1", 32'hA5A5_0004, 32'h8,  1'b1); chk_req("seq1", 1'b1, 32'h8);
    tick(); chk_ifid("seq2", 32'hA5A5_0008, 32'hC,  1'b1); chk_req("seq2", 1'b1, 32'hC);
    tick(); chk_ifid("seq3", 32'hA5A5_000C, 32'h10, 1'b1); chk_req("seq3", 1'b1, 32'h10);

    // Ack withheld three cycles
    bus.imem_ack = 1'b0;
    tick(); chk_ifid("wait0", 32'h0, 32'h10, 1'b0); chk_req("wait0", 1'b1, 32'h10);
    tick(); chk_ifid("wait1", 32'h0, 32'h10, 1'b0); chk_req("wait1", 1'b1, 32'h10);
    tick(); chk_ifid("wait2", 32'h0, 32'h10, 1'b0); chk_req("wait2", 1'b1, 32'h10);
    bus.imem_ack = 1'b1;
    tick(); chk_ifid("ackd", 32'hA5A5_0010, 32'h14, 1'b1); chk_req("ackd", 1'b1, 32'h14);

    // Stall lands on the fetch of 0x14: it is parked, IF/ID holds
    bus.stall = 1'b1;
    tick(); chk_ifid("stall0", 32'hA5A5_0010, 32'h14, 1'b1); chk_req("stall0", 1'b0, 32'h0);
    tick(); chk_ifid("stall1", 32'hA5A5_0010, 32'h14, 1'b1); chk_req("stall1", 1'b0, 32'h0);
    bus.stall = 1'b0;
    tick(); chk_ifid("drain", 32'hA5A5_0014, 32'h18, 1'b1); chk_req("drain", 1'b1, 32'h18);
    tick(); chk_ifid("resume", 32'hA5A5_0018, 32'h1C, 1'b1); chk_req("resume", 1'b1, 32'h1C);

    // Redirect while the request to 0x1C is unacked
    bus.imem_ack    = 1'b0;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0103;
    tick(); chk_ifid("redir", 32'h0, 32'h1C, 1'b0); chk_req("redir", 1'b1, 32'h1C);
    bus.redirect = 1'b0;
    tick(); check("drop.valid", {31'h0, bus.if_valid}, 32'h0); chk_req("drop", 1'b1, 32'h1C);
    bus.imem_ack = 1'b1;
    tick(); chk_ifid("dropack", 32'h0, 32'h1C, 1'b0); chk_req("dropack", 1'b1, 32'h100);
    tick(); chk_ifid("target", 32'hA5A5_0100, 32'h104, 1'b1); chk_req("target", 1'b1, 32'h104);

    // Redirect and Stall together with the pending entry full
    bus.stall = 1'b1;
    tick(); chk_req("pendfull", 1'b0, 32'h0);
    check("pendfull.im", bus.im, 32'hA5A5_0100);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0200;
    tick(); check("rs.valid", {31'h0, bus.if_valid}, 32'h0); check("rs.im", bus.im, 32'h0);
    chk_req("rs", 1'b1, 32'h200);
    bus.redirect = 1'b0;
    bus.stall    = 1'b0;
    tick(); chk_ifid("rs.after", 32'hA5A5_0200, 32'h204, 1'b1);

    // PC wraps at the top of the address space
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFE;
    tick(); chk_req("wrap.req", 1'b1, 32'hFFFF_FFFC);
    bus.redirect = 1'b0;
    tick(); chk_ifid("wrap", 32'hA5A5_FFFC, 32'h0, 1'b1); chk_req("wrap", 1'b1, 32'h0);

`ifdef IF_PERF_CNT_EN
    check("perf.fetch", fetch_count, 32'd10);
    check("perf.stall", stall_count, 32'd4);
`endif

    // Asynchronous reset between clock edges abandons the request
    #2 rst_n = 1'b0;
    #1;
    chk_ifid("areset", 32'h0, 32'h0, 1'b0);
    chk_req("areset", 1'b0, 32'h0);
`ifdef IF_PERF_CNT_EN
    check("areset.fetch", fetch_count, 32'd0);
    check("areset.stall", stall_count, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick(); chk_req("restart", 1'b1, 32'h0);
    tick(); chk_ifid("restart", 32'hA5A5_0000, 32'h4, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
